// File: rtl/port_bridge.sv
// Host-side I/O bridge: an input FIFO feeding the CPU in_port and an output FIFO
// capturing every OUT word for the host, both with registered storage.
module port_bridge #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] host_in_data,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  output logic [WIDTH-1:0] in_port,
  output logic             in_avail,
  input  logic             in_ack,
  input  logic [WIDTH-1:0] out_port,
  input  logic             out_strobe,
  output logic [WIDTH-1:0] host_out_data,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] r_in_mem [DEPTH];
  logic [PW-1:0]    r_in_wp;
  logic [PW-1:0]    r_in_rp;
  logic [CW-1:0]    r_in_cnt;
  logic [WIDTH-1:0] r_in_last;

  logic [WIDTH-1:0] r_out_mem [DEPTH];
  logic [PW-1:0]    r_out_wp;
  logic [PW-1:0]    r_out_rp;
  logic [CW-1:0]    r_out_cnt;
  logic             r_ovf;

  logic w_in_push;
  logic w_in_pop;
  logic w_out_pop;
  logic w_out_push;

  assign host_in_ready  = (r_in_cnt < LP_DEPTH);
  assign in_avail       = (r_in_cnt != '0);
  assign w_in_push      = host_in_valid && host_in_ready;
  assign w_in_pop       = in_ack && in_avail;
  // Empty FIFO keeps showing the most recently consumed word rather than stale storage.
  assign in_port        = in_avail ? r_in_mem[r_in_rp] : r_in_last;

  assign host_out_valid = (r_out_cnt != '0);
  assign host_out_data  = r_out_mem[r_out_rp];
  assign w_out_pop      = host_out_valid && host_out_ready;
  // A full FIFO still accepts the strobe when the host frees a slot in the same cycle.
  assign w_out_push     = out_strobe && ((r_out_cnt < LP_DEPTH) || w_out_pop);
  assign overflow       = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_in_mem[i] <= '0;
      r_in_wp   <= '0;
      r_in_rp   <= '0;
      r_in_cnt  <= '0;
      r_in_last <= '0;
    end else begin
      if (w_in_push) begin
        r_in_mem[r_in_wp] <= host_in_data;
        r_in_wp           <= r_in_wp + PW'(1);
      end
      if (w_in_pop) begin
        r_in_last <= r_in_mem[r_in_rp];
        r_in_rp   <= r_in_rp + PW'(1);
      end
      if (w_in_push && !w_in_pop)      r_in_cnt <= r_in_cnt + CW'(1);
      else if (w_in_pop && !w_in_push) r_in_cnt <= r_in_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_out_mem[i] <= '0;
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_out_push) begin
        r_out_mem[r_out_wp] <= out_port;
        r_out_wp            <= r_out_wp + PW'(1);
      end
      if (w_out_pop) r_out_rp <= r_out_rp + PW'(1);
      if (out_strobe && !w_out_push) r_ovf <= 1'b1;
      if (w_out_push && !w_out_pop)      r_out_cnt <= r_out_cnt + CW'(1);
      else if (w_out_pop && !w_out_push) r_out_cnt <= r_out_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_port_bridge.sv
// Bench for port_bridge: directed vector table, hand sequences and random
// traffic, all checked against a queue-based model of the two FIFOs.
module tb_port_bridge;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] hid;
  logic             hiv;
  logic             hir;
  logic [WIDTH-1:0] in_port;
  logic             in_avail;
  logic             in_ack;
  logic [WIDTH-1:0] out_port;
  logic             out_strobe;
  logic [WIDTH-1:0] hod;
  logic             hov;
  logic             hor;
  logic             ovf;

  port_bridge #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .host_in_data(hid), .host_in_valid(hiv), .host_in_ready(hir),
    .in_port(in_port), .in_avail(in_avail), .in_ack(in_ack),
    .out_port(out_port), .out_strobe(out_strobe),
    .host_out_data(hod), .host_out_valid(hov), .host_out_ready(hor),
    .overflow(ovf)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: plain queues and the FIFO rules.
  logic [WIDTH-1:0] q_in[$];
  logic [WIDTH-1:0] q_out[$];
  logic [WIDTH-1:0] m_last;
  logic             m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_edge();
    bit pin, pop, opop, acc;
    if (rst) begin
      q_in.delete(); q_out.delete(); m_last = '0; m_ovf = 1'b0;
    end else begin
      pin  = hiv && (q_in.size() < DEPTH);
      pop  = in_ack && (q_in.size() > 0);
      opop = hor && (q_out.size() > 0);
      acc  = out_strobe && ((q_out.size() < DEPTH) || opop);
      if (pop) m_last = q_in.pop_front();
      if (pin) q_in.push_back(hid);
      if (opop) void'(q_out.pop_front());
      if (acc) q_out.push_back(out_port);
      if (out_strobe && !acc) m_ovf = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("m_in_port", in_port, (q_in.size() > 0) ? q_in[0] : m_last);
    chk("m_in_avail", in_avail, q_in.size() > 0);
    chk("m_host_in_ready", hir, q_in.size() < DEPTH);
    chk("m_host_out_valid", hov, q_out.size() > 0);
    if (q_out.size() > 0) chk("m_host_out_data", hod, q_out[0]);
    chk("m_overflow", ovf, m_ovf);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    rst = 0; hiv = 0; hid = '0; in_ack = 0; out_strobe = 0; out_port = '0; hor = 0;
  endtask

  typedef struct {
    logic [15:0] d_in; logic v_in; logic ack;
    logic [15:0] d_out; logic stb; logic rdy;
    logic [15:0] e_port; logic e_avail; logic e_rdy;
    logic e_hov; logic [15:0] e_hod; logic e_ovf;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // d_in v ack d_out stb rdy | in_port avail hir hov hod ovf
    tbl[0]  = '{16'h1111,1,0,16'h0,0,0, 16'h1111,1,1, 0,16'h0,0};
    tbl[1]  = '{16'h2222,1,0,16'h0,0,0, 16'h1111,1,1, 0,16'h0,0};
    tbl[2]  = '{16'h3333,1,0,16'h0,0,0, 16'h1111,1,1, 0,16'h0,0};
    tbl[3]  = '{16'h4444,1,0,16'h0,0,0, 16'h1111,1,0, 0,16'h0,0};
    tbl[4]  = '{16'h5555,1,0,16'h0,0,0, 16'h1111,1,0, 0,16'h0,0};
    tbl[5]  = '{16'h0,0,1,16'h0,0,0,    16'h2222,1,1, 0,16'h0,0};
    tbl[6]  = '{16'h0,0,1,16'h0,0,0,    16'h3333,1,1, 0,16'h0,0};
    tbl[7]  = '{16'h0,0,1,16'h0,0,0,    16'h4444,1,1, 0,16'h0,0};
    tbl[8]  = '{16'h0,0,1,16'h0,0,0,    16'h4444,0,1, 0,16'h0,0};
    tbl[9]  = '{16'h0,0,1,16'h0,0,0,    16'h4444,0,1, 0,16'h0,0};
    tbl[10] = '{16'h0,0,0,16'h00FF,1,0, 16'h4444,0,1, 1,16'h00FF,0};
    tbl[11] = '{16'h0,0,0,16'h0100,1,0, 16'h4444,0,1, 1,16'h00FF,0};
    tbl[12] = '{16'h0,0,0,16'hBEEF,1,0, 16'h4444,0,1, 1,16'h00FF,0};
    tbl[13] = '{16'h0,0,0,16'h0,0,0,    16'h4444,0,1, 1,16'h00FF,0};
    tbl[14] = '{16'h0,0,0,16'h0,0,1,    16'h4444,0,1, 1,16'h0100,0};
    tbl[15] = '{16'h0,0,0,16'h0,0,1,    16'h4444,0,1, 1,16'hBEEF,0};
    tbl[16] = '{16'h0,0,0,16'h0,0,1,    16'h4444,0,1, 0,16'h0,0};

    idle();
    // Reset with every input active.
    rst = 1; hiv = 1; hid = 16'h9999; in_ack = 1; out_strobe = 1; out_port = 16'h7777; hor = 1;
    step(); step();
    idle();
    #1;
    chk("rst_in_port", in_port, 16'h0000);
    chk("rst_in_avail", in_avail, 1'b0);
    chk("rst_host_in_ready", hir, 1'b1);
    chk("rst_host_out_valid", hov, 1'b0);
    chk("rst_host_out_data", hod, 16'h0000);
    chk("rst_overflow", ovf, 1'b0);

    for (int i = 0; i < 17; i++) begin
      hid = tbl[i].d_in; hiv = tbl[i].v_in; in_ack = tbl[i].ack;
      out_port = tbl[i].d_out; out_strobe = tbl[i].stb; hor = tbl[i].rdy;
      step();
      chk($sformatf("v%0d_in_port", i), in_port, tbl[i].e_port);
      chk($sformatf("v%0d_in_avail", i), in_avail, tbl[i].e_avail);
      chk($sformatf("v%0d_host_in_ready", i), hir, tbl[i].e_rdy);
      chk($sformatf("v%0d_host_out_valid", i), hov, tbl[i].e_hov);
      if (tbl[i].e_hov) chk($sformatf("v%0d_host_out_data", i), hod, tbl[i].e_hod);
      chk($sformatf("v%0d_overflow", i), ovf, tbl[i].e_ovf);
    end
    idle();

    // Simultaneous push/pop with two words queued.
    hiv = 1; hid = 16'hA001; step(); hid = 16'hA002; step();
    hid = 16'hAAAA; in_ack = 1; step();
    chk("pp_head", in_port, 16'hA002);
    idle(); in_ack = 1; step();
    chk("pp_next", in_port, 16'hAAAA);
    step();
    chk("pp_empty", in_avail, 1'b0);
    step();
    chk("pp_ack_empty_port", in_port, 16'hAAAA);
    chk("pp_ack_empty_ready", hir, 1'b1);
    idle();

    // Overflow: fill output FIFO, drop a word, then accept one with simultaneous pop.
    out_strobe = 1;
    for (int i = 0; i < DEPTH; i++) begin out_port = 16'(16'h0C00 + i); step(); end
    out_port = 16'hDEAD; step();
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_head", hod, 16'h0C00);
    out_strobe = 0; step(); step();
    chk("ovf_sticky", ovf, 1'b1);
    out_strobe = 1; out_port = 16'hCAFE; hor = 1; step();
    out_strobe = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("ovf_last_cafe", hod, 16'hCAFE);
      step();
    end
    chk("ovf_drained", hov, 1'b0);
    chk("ovf_still_set", ovf, 1'b1);
    idle();

    // Ten words through each FIFO concurrently, crossing pointer wrap.
    for (int i = 0; i < 10; i++) begin
      hiv = 1; hid = 16'(16'h5000 + i); in_ack = (i > 0);
      out_strobe = 1; out_port = 16'(16'h6000 + i); hor = (i > 0);
      step();
    end
    idle(); in_ack = 1; hor = 1; step();
    chk("wrap_in_last", in_port, 16'h5009);
    chk("wrap_out_empty", hov, 1'b0);
    idle();

    // Mid-operation reset with both FIFOs half full.
    hiv = 1; out_strobe = 1;
    for (int i = 0; i < DEPTH / 2; i++) begin hid = 16'(16'h7100 + i); out_port = 16'(16'h7200 + i); step(); end
    idle(); rst = 1; step(); rst = 0;
    chk("mid_rst_in_avail", in_avail, 1'b0);
    chk("mid_rst_in_port", in_port, 16'h0000);
    chk("mid_rst_out_valid", hov, 1'b0);
    chk("mid_rst_out_data", hod, 16'h0000);
    chk("mid_rst_ovf", ovf, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      hiv = $urandom_range(0, 1); hid = 16'($urandom);
      in_ack = $urandom_range(0, 1);
      out_strobe = $urandom_range(0, 1); out_port = 16'($urandom);
      hor = ($urandom_range(0, 2) != 0);
      step();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
